// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared types and constants for the instruction prefetch queue
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - circular buffer holding fetched {fault, pc, inst} entries
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - sequential instruction prefetcher with redirect flush feeding IF/ID
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] iaddr_o,
    output logic [31:0] idat_o,
    output logic [3:0]  isel_o,
    output logic        icyc_o,
    output logic        istb_o,
    output logic        iwe_o,
    input  logic [31:0] idat_i,
    input  logic        iack_i,
    input  logic        ierr_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  iaddr_q, iaddr_d;
    logic         icyc_q, icyc_d;

    logic [CW-1:0] fifo_count;
    fq_entry_t     head;
    fq_entry_t     push_entry;
    logic          fifo_empty;
    logic          fifo_full;
    logic          resp, push, pop, space;
    logic [CW:0]   count_after;
    logic          unused_ok;

    assign resp  = iack_i | ierr_i;
    assign pop   = !fifo_empty && !stall_i;
    assign push  = (state_q == ST_REQ) && resp && !redirect_i;

    // Space is judged on the occupancy after this edge so the single
    // outstanding response always finds a free slot.
    assign count_after = {1'b0, fifo_count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign space       = count_after < (CW+1)'(DEPTH);

    assign push_entry = '{fault: ierr_i, pc: iaddr_q, inst: ierr_i ? NOP_INST : idat_i};

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  (push_entry),
        .count_o (fifo_count),
        .head_o  (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            iaddr_q    <= '0;
            icyc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            iaddr_q    <= iaddr_d;
            icyc_q     <= icyc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            // A request still open on the bus must be allowed to finish.
            if ((state_q == ST_REQ || state_q == ST_DRAIN) && !resp) state_d = ST_DRAIN;
            else                                                      state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (space) state_d = ST_REQ;
                ST_REQ: begin
                    if (ierr_i) begin
                        state_d = ST_HALT;
                    end else if (iack_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = space ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DRAIN: if (resp) state_d = ST_IDLE;
                default:  state_d = ST_HALT;
            endcase
        end
    end

    always_comb begin
        icyc_d  = (state_d == ST_REQ) || (state_d == ST_DRAIN);
        iaddr_d = iaddr_q;
        if (state_d == ST_REQ && (state_q != ST_REQ || iack_i)) iaddr_d = fetch_pc_d;
    end

    assign iaddr_o = iaddr_q;
    assign icyc_o  = icyc_q;
    assign istb_o  = icyc_q;
    assign idat_o  = 32'h0000_0000;
    assign isel_o  = 4'hF;
    assign iwe_o   = 1'b0;

    assign valid_o = !fifo_empty;
    assign inst_o  = fifo_empty ? NOP_INST : head.inst;
    assign pc_o    = fifo_empty ? 32'h0000_0000 : head.pc;
    assign fault_o = !fifo_empty && head.fault;

    assign unused_ok = ^{redirect_pc_i[1:0], fifo_full};

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for the instruction prefetch queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        valid_o, fault_o, icyc_o, istb_o, iwe_o;
    logic [31:0] inst_o, pc_o, iaddr_o, idat_o, idat_i;
    logic [3:0]  isel_o;
    logic        iack_i, ierr_i, ready;

    int          delay = 0;
    int          wcnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_queue dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i), .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o),
        .fault_o(fault_o), .iaddr_o(iaddr_o), .idat_o(idat_o), .isel_o(isel_o),
        .icyc_o(icyc_o), .istb_o(istb_o), .iwe_o(iwe_o), .idat_i(idat_i),
        .iack_i(iack_i), .ierr_i(ierr_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: responds once a request has been open for `delay` cycles.
    assign ready  = icyc_o && (wcnt >= delay);
    assign ierr_i = ready && err_en && (iaddr_o == err_addr);
    assign iack_i = ready && !ierr_i;
    assign idat_i = memword(iaddr_o);

    always @(posedge clk) begin
        if (!icyc_o || iack_i || ierr_i) wcnt <= 0;
        else                             wcnt <= wcnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        cyc;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t        vecs[12];
    logic        found;
    logic [31:0] first_addr;
    logic [31:0] wrap_pcs[4];
    int          j;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
        vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vecs[6]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
        vecs[7]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h08};
        vecs[8]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[9]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[10] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[11] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h18};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_cyc",   32'(icyc_o),  32'd0);
        chk("rst_stb",   32'(istb_o),  32'd0);
        chk("rst_iaddr", iaddr_o,      32'h0);
        chk("rst_inst",  inst_o,       NOP);
        chk("rst_pc",    pc_o,         32'h0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_isel",  32'(isel_o),  32'hF);
        chk("rst_iwe",   32'(iwe_o),   32'd0);
        chk("rst_idat",  idat_o,       32'h0);
        rst = 1'b0;

        // Streaming with a stall window that fills the queue.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_cyc", k),   32'(icyc_o),  32'(vecs[k].cyc));
            chk($sformatf("v%0d_stb", k),   32'(istb_o),  32'(vecs[k].cyc));
            chk($sformatf("v%0d_addr", k),  iaddr_o,      vecs[k].addr);
            chk($sformatf("v%0d_valid", k), 32'(valid_o), 32'(vecs[k].valid));
            chk($sformatf("v%0d_pc", k),    pc_o,         vecs[k].pc);
            if (vecs[k].valid) chk($sformatf("v%0d_inst", k), inst_o, memword(vecs[k].pc));
            stall_i = vecs[k].stall;
        end

        // Stall held from reset: four entries, bus idles, then drain in order.
        stall_i = 1'b1;
        do_reset();
        repeat (7) @(negedge clk);
        chk("full_cyc",   32'(icyc_o),  32'd0);
        chk("full_valid", 32'(valid_o), 32'd1);
        chk("full_pc",    pc_o,         32'h0);
        stall_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_pc", i), pc_o, 32'(4 * (i + 1)));
            if (i == 0) begin
                chk("resume_cyc",  32'(icyc_o), 32'd1);
                chk("resume_addr", iaddr_o,     32'h10);
            end
        end

        // Redirect while a slow request to 8 is open.
        delay = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (icyc_o && iaddr_o == 32'h8) found = 1'b1;
        end
        chk("rd_found_req8", 32'(found), 32'd1);
        redirect_pc_i = 32'h0000_0103;
        redirect_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("rd_valid0",  32'(valid_o), 32'd0);
        chk("rd_hold_cyc", 32'(icyc_o), 32'd1);
        chk("rd_hold_addr", iaddr_o,    32'h8);
        @(negedge clk);
        chk("rd_hold2_addr", iaddr_o, 32'h8);
        first_addr = 32'hDEAD_BEEF;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (icyc_o && iaddr_o != 32'h8 && first_addr == 32'hDEAD_BEEF) first_addr = iaddr_o;
            if (valid_o) begin
                found = 1'b1;
                chk("rd_first_pc",   pc_o,   32'h100);
                chk("rd_first_inst", inst_o, memword(32'h100));
            end
        end
        chk("rd_found_valid", 32'(found), 32'd1);
        chk("rd_first_addr",  first_addr, 32'h100);
        delay = 0;

        // Bus error on 0x20 halts fetching until a redirect.
        err_en = 1'b1;
        err_addr = 32'h20;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (valid_o && pc_o == 32'h1C) found = 1'b1;
        end
        chk("err_found_1c", 32'(found), 32'd1);
        chk("err_pre_fault", 32'(fault_o), 32'd0);
        @(negedge clk);
        chk("err_valid", 32'(valid_o), 32'd1);
        chk("err_pc",    pc_o,         32'h20);
        chk("err_fault", 32'(fault_o), 32'd1);
        chk("err_inst",  inst_o,       NOP);
        chk("err_cyc",   32'(icyc_o),  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_cyc", i),   32'(icyc_o),  32'd0);
            chk($sformatf("halt%0d_valid", i), 32'(valid_o), 32'd0);
        end
        redirect_pc_i = 32'h40;
        redirect_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        err_en = 1'b0;
        chk("herr_valid0", 32'(valid_o), 32'd0);
        @(negedge clk);
        chk("herr_cyc",  32'(icyc_o), 32'd1);
        chk("herr_addr", iaddr_o,     32'h40);
        @(negedge clk);
        chk("herr_pc",    pc_o,         32'h40);
        chk("herr_fault", 32'(fault_o), 32'd0);

        // Address wrap at the top of memory.
        wrap_pcs[0] = 32'hFFFF_FFF8;
        wrap_pcs[1] = 32'hFFFF_FFFC;
        wrap_pcs[2] = 32'h0000_0000;
        wrap_pcs[3] = 32'h0000_0004;
        do_reset();
        @(negedge clk);
        redirect_pc_i = 32'hFFFF_FFF8;
        redirect_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("wrap_valid0", 32'(valid_o), 32'd0);
        j = 0;
        for (int i = 0; i < 12 && j < 4; i++) begin
            @(negedge clk);
            if (valid_o) begin
                chk($sformatf("wrap%0d_pc", j), pc_o, wrap_pcs[j]);
                j++;
            end
        end
        chk("wrap_count", 32'(j), 32'd4);

        // Reset while a slow request is open.
        delay = 3;
        do_reset();
        @(negedge clk);
        chk("mrst_cyc_before", 32'(icyc_o), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_cyc",   32'(icyc_o),  32'd0);
        chk("mrst_valid", 32'(valid_o), 32'd0);
        delay = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_refetch_cyc",  32'(icyc_o), 32'd1);
        chk("mrst_refetch_addr", iaddr_o,     32'h0);
        @(negedge clk);
        chk("mrst_refetch_pc",    pc_o,         32'h0);
        chk("mrst_refetch_valid", 32'(valid_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch unit upstream of the IF/ID pipeline register.
- Issues sequential single-word reads on the instruction bus (cyc/stb/ack/err handshake, same bus as the block RAM instruction port).
- Buffers fetched words with their PCs in a small FIFO and presents them to the IF/ID register with a valid/stall handshake.
- Handles control-flow redirects by flushing the buffer and discarding any in-flight response.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- stall_i  in  1  downstream not accepting; head is held.
- valid_o  out  1  head entry valid.
- inst_o  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- pc_o  out  32  head PC; 0 when empty.
- fault_o  out  1  head entry is a bus-error entry.
- iaddr_o  out  32  bus address.
- idat_o  out  32  bus write data; constant 0.
- isel_o  out  4  byte select; constant 4'hF.
- icyc_o  out  1  bus cycle.
- istb_o  out  1  bus strobe; always equals icyc_o.
- iwe_o  out  1  write enable; constant 0.
- idat_i  in  32  bus read data.
- iack_i  in  1  read complete.
- ierr_i  in  1  bus error.

Behaviour:
- Reset:
  - FIFO count 0.
  - fetch_pc = RESET_PC.
  - State IDLE.
  - icyc_o = istb_o = 0, iaddr_o = 0.
  - valid_o = 0, fault_o = 0, inst_o = NOP, pc_o = 0.
- All bus outputs are registered. At most one request is outstanding.
- Pop: occurs when valid_o=1 and stall_i=0 at the clock edge. The next entry (or empty) appears the following cycle.
- Push: on iack_i or ierr_i while in REQ. The pushed entry is {fault=ierr_i, pc=iaddr_o, inst=ierr_i ? NOP : idat_i}. If ack and err are both high, err wins.
- Space rule: a request may be issued only if count < DEPTH, counting a pop in the same cycle. This guarantees a push never overflows.
- Simultaneous push and pop in one cycle: count is unchanged.
- fetch_pc increments by 4 modulo 2^32 on each accepted ack. 32'hFFFF_FFFC wraps to 0.
- FSM states:
  - IDLE: if space → drive cyc/stb=1, iaddr_o=fetch_pc → REQ.
  - REQ: hold cyc/stb/iaddr_o until ack or err.
    - On ack: push. If space remains after this edge, issue the next address back-to-back (cyc stays 1, iaddr_o=fetch_pc+4) and stay in REQ. Otherwise drop cyc/stb → IDLE.
    - On err: push a fault entry, drop cyc/stb → HALT.
  - HALT: no fetching; FIFO continues to drain; leave only on redirect.
  - DRAIN: keep cyc/stb asserted with the old address until ack or err. Discard the response (no push), drop cyc/stb → IDLE.
- Redirect (highest priority; overrides push and pop in the same cycle):
  - count ← 0; fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
  - From REQ with no ack/err this cycle → DRAIN.
  - From REQ with ack/err this cycle → the response is discarded → IDLE.
  - From IDLE or HALT → IDLE.
  - In DRAIN: update fetch_pc, stay in DRAIN.
  - valid_o = 0 in the cycle after a redirect.
- Latency:
  - First request is on the bus the cycle after rst deasserts.
  - With a 1-cycle-ack memory, the first valid_o occurs 2 cycles after the request is issued.
  - Sustained rate: 1 instruction/cycle while stall_i=0 and the memory acks every cycle.
- Reset mid-transaction: the bus drops immediately and any later ack is ignored (state IDLE, cyc=0).

Decomposition:
- Shared package:
  - NOP_INST = 32'h0000_0013.
  - fetch state encoding {IDLE, REQ, DRAIN, HALT}.
  - FIFO entry layout {fault, pc[31:0], inst[31:0]} (65 bits).
- Sub-module fetch_fifo:
  - Parameterized DEPTH, 65-bit wide.
  - Inputs push, pop, flush. Outputs count, head, empty, full.
  - Synchronous reset/flush; pointers wrap modulo DEPTH.

Test Plan:
- Reset release, memory acks in 1 cycle, stall_i=0 → iaddr_o 0,4,8,...; valid_o with pc_o 0,4,8 on consecutive cycles; inst_o = memory words.
- stall_i=1 held → exactly 4 entries buffered, icyc_o drops, head stays pc_o=0; release stall → pops 0,4,8,12 in order, fetch resumes at 16.
- redirect_i with redirect_pc_i=32'h0000_0103 while a request to 8 is pending and ack is delayed 3 cycles → cyc held until ack, data discarded, next request at 32'h100, first valid pc_o=32'h100.
- ierr_i on the fetch of 32'h20 → fault entry with pc_o=32'h20, inst_o=NOP, fault_o=1; no further requests until redirect to 0x40, then fetch resumes at 0x40.
- Redirect to 32'hFFFF_FFF8 → fetches FFFF_FFF8, FFFF_FFFC, then 0; pc_o sequence matches.
- rst asserted mid-REQ with a pending ack → icyc_o=0 next cycle, valid_o=0, refetch from RESET_PC.
